// File: rtl/sprite_line_engine_if.sv
// sprite_line_engine_if: sprite ROM read bus, engine is master, ROM is slave
interface sprite_line_engine_if #(
  parameter int SPR_W = 16,
  parameter int ADDRW = 4
);
  logic             rom_en;
  logic [ADDRW-1:0] rom_addr;
  logic [SPR_W-1:0] rom_data;
  modport master (output rom_en, rom_addr, input rom_data);
  modport slave  (input rom_en, rom_addr, output rom_data);
endinterface

// File: rtl/sprite_line_engine.sv
// sprite_line_engine: fetches one sprite row per active line and shifts it out as pixel coverage
module sprite_line_engine #(
  parameter int CORDW   = 16,
  parameter int SPR_W   = 16,
  parameter int SPR_H   = 16,
  parameter int ADDRW   = 4,
  parameter int ROM_LAT = 1
) (
  input  logic                    clk_pix,
  input  logic                    rst_n,
  input  logic                    frame,
  input  logic                    line,
  input  logic                    de,
  input  logic signed [CORDW-1:0] screen_x,
  input  logic signed [CORDW-1:0] screen_y,
  input  logic signed [CORDW-1:0] spr_x,
  input  logic signed [CORDW-1:0] spr_y,
  input  logic                    spr_en,
  sprite_line_engine_if.master    rom,
  output logic                    pix_on,
  output logic                    pix_de
);
  localparam int CW = $clog2(SPR_W);
  localparam logic signed [CORDW-1:0] SH = CORDW'(SPR_H);
  typedef enum logic [2:0] {IDLE, FETCH, WAIT, READY, DRAW} state_t;
  state_t                  state_q;
  logic signed [CORDW-1:0] sx_l_q, sy_l_q, row;
  logic                    en_l_q, hit, drawing;
  logic [SPR_W-1:0]        bits_q;
  logic [CW-1:0]           cnt_q;
  logic                    rom_en_q, pix_on_q, pix_de_q;
  logic [ADDRW-1:0]        rom_addr_q;
  // a coincident frame pulse latches first, so the line sees the new position
  always_comb begin
    row     = screen_y - (frame ? spr_y : sy_l_q);
    hit     = (frame ? spr_en : en_l_q) && !row[CORDW-1] && row < SH;
    drawing = state_q == DRAW || (state_q == READY && screen_x == sx_l_q);
  end
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sx_l_q     <= '0;
      sy_l_q     <= '0;
      en_l_q     <= 1'b0;
      bits_q     <= '0;
      cnt_q      <= '0;
      rom_en_q   <= 1'b0;
      rom_addr_q <= '0;
      pix_on_q   <= 1'b0;
      pix_de_q   <= 1'b0;
    end else begin
      pix_de_q <= de;
      pix_on_q <= de && drawing && bits_q[SPR_W-1];
      rom_en_q <= 1'b0;
      if (frame) begin
        sx_l_q <= spr_x;
        sy_l_q <= spr_y;
        en_l_q <= spr_en;
      end
      if (line) begin
        state_q    <= hit ? FETCH : IDLE;
        rom_en_q   <= hit;
        rom_addr_q <= hit ? row[ADDRW-1:0] : rom_addr_q;
        bits_q     <= hit ? bits_q : '0;
      end else begin
        case (state_q)
          FETCH: begin
            cnt_q   <= CW'(ROM_LAT - 1);
            state_q <= WAIT;
          end
          WAIT: begin
            cnt_q   <= cnt_q == '0 ? cnt_q : cnt_q - CW'(1);
            bits_q  <= cnt_q == '0 ? rom.rom_data : bits_q;
            state_q <= cnt_q == '0 ? READY : WAIT;
          end
          // the match cycle emits the leftmost pixel, DRAW emits the remaining SPR_W-1
          READY: if (drawing) begin
            bits_q  <= bits_q << 1;
            cnt_q   <= CW'(SPR_W - 1);
            state_q <= DRAW;
          end
          DRAW: begin
            bits_q  <= cnt_q == CW'(1) ? '0 : bits_q << 1;
            cnt_q   <= cnt_q - CW'(1);
            state_q <= cnt_q == CW'(1) ? IDLE : DRAW;
          end
          default: ;
        endcase
      end
    end
  end
  assign rom.rom_en   = rom_en_q;
  assign rom.rom_addr = rom_addr_q;
  assign pix_on       = pix_on_q;
  assign pix_de       = pix_de_q;
endmodule

// File: tb/tb_sprite_line_engine.sv
// tb_sprite_line_engine: two engines (ROM latency 1 and 4) checked per cycle against a pixel-rule model
module tb_sprite_line_engine;
  logic clk_pix = 1'b0, rst_n = 1'b0;
  logic frame = 1'b0, line = 1'b0, de = 1'b0, spr_en = 1'b0;
  logic signed [15:0] screen_x = '0, screen_y = '0, spr_x = '0, spr_y = '0;
  logic pix_on1, pix_de1, pix_on4, pix_de4;
  logic [15:0] mem [16];
  logic [15:0] pa [4], pb [4];
  int errs = 0, checks = 0, pixcnt = 0, pixcnt4 = 0, fetchcnt = 0;
  logic signed [15:0] m_sx = '0, m_sy = '0;
  logic m_en = 1'b0, m_hit = 1'b0;
  logic [15:0] m_bits = '0;
  logic [3:0] m_addr = '0;
  sprite_line_engine_if #(.SPR_W(16), .ADDRW(4)) rb1 ();
  sprite_line_engine_if #(.SPR_W(16), .ADDRW(4)) rb4 ();
  sprite_line_engine #(.ROM_LAT(1)) dut1 (
    .clk_pix(clk_pix), .rst_n(rst_n), .frame(frame), .line(line), .de(de),
    .screen_x(screen_x), .screen_y(screen_y), .spr_x(spr_x), .spr_y(spr_y),
    .spr_en(spr_en), .rom(rb1), .pix_on(pix_on1), .pix_de(pix_de1));
  sprite_line_engine #(.ROM_LAT(4)) dut4 (
    .clk_pix(clk_pix), .rst_n(rst_n), .frame(frame), .line(line), .de(de),
    .screen_x(screen_x), .screen_y(screen_y), .spr_x(spr_x), .spr_y(spr_y),
    .spr_en(spr_en), .rom(rb4), .pix_on(pix_on4), .pix_de(pix_de4));
  always #5 clk_pix = ~clk_pix;
  // ROM returns garbage unless strobed, so a mistimed load shows up as wrong pixels
  always @(posedge clk_pix) begin
    pa[0] <= rb1.rom_en ? mem[rb1.rom_addr] : 16'($urandom);
    pb[0] <= rb4.rom_en ? mem[rb4.rom_addr] : 16'($urandom);
    for (int i = 1; i < 4; i++) begin
      pa[i] <= pa[i-1];
      pb[i] <= pb[i-1];
    end
  end
  assign rb1.rom_data = pa[0];
  assign rb4.rom_data = pb[3];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic exp_pix(input int lat);
    int d;
    d = int'(screen_x) - int'(m_sx);
    if (!(rst_n && de && m_hit && d >= 0 && d < 16)) return 1'b0;
    if (int'(m_sx) < -160 + 2 + lat) return 1'b0;
    return m_bits[15-d];
  endfunction
  task automatic step();
    logic e_en, e_p1, e_p4, e_de;
    int r;
    if (!rst_n) begin
      m_en = 1'b0; m_sx = '0; m_sy = '0; m_hit = 1'b0;
    end else begin
      if (frame) begin
        m_sx = spr_x; m_sy = spr_y; m_en = spr_en;
      end
      if (line) begin
        r = int'(screen_y) - int'(m_sy);
        m_hit  = m_en && r >= 0 && r < 16;
        m_addr = r[3:0];
        m_bits = m_hit ? mem[r[3:0]] : 16'h0;
      end
    end
    e_en = rst_n && line && m_hit;
    e_de = rst_n && de;
    e_p1 = exp_pix(1);
    e_p4 = exp_pix(4);
    @(posedge clk_pix); #1;
    chk("pix_on1", pix_on1, e_p1);
    chk("pix_on4", pix_on4, e_p4);
    chk("pix_de1", pix_de1, e_de);
    chk("pix_de4", pix_de4, e_de);
    chk("rom_en1", rb1.rom_en, e_en);
    chk("rom_en4", rb4.rom_en, e_en);
    if (e_en) begin
      chk("rom_addr1", rb1.rom_addr, m_addr);
      chk("rom_addr4", rb4.rom_addr, m_addr);
    end
    if (pix_on1) pixcnt++;
    if (pix_on4) pixcnt4++;
    if (rb1.rom_en) fetchcnt++;
  endtask
  task automatic run_line(input int yy, input int rst_at = 9999);
    for (int xx = -160; xx < 640; xx++) begin
      if (xx == rst_at) begin
        #2 rst_n = 1'b0;
        #1;
        chk("rst_pix_on", pix_on1, 0);
        chk("rst_pix_de", pix_de1, 0);
        chk("rst_rom_en", rb1.rom_en, 0);
      end
      if (xx == rst_at + 3) rst_n = 1'b1;
      frame = 1'b0;
      line = xx == -160;
      screen_x = 16'(xx);
      screen_y = 16'(yy);
      de = xx >= 0 && yy >= 0;
      step();
    end
  endtask
  task automatic do_frame(input int sx, input int sy, input logic en);
    spr_x = 16'(sx); spr_y = 16'(sy); spr_en = en;
    frame = 1'b1; line = 1'b0; de = 1'b0;
    screen_x = 16'(-160); screen_y = 16'(-45);
    step();
    frame = 1'b0;
    repeat (4) begin
      screen_x = screen_x + 16'sd1;
      step();
    end
  endtask
  task automatic fill(input logic [15:0] v);
    for (int i = 0; i < 16; i++) mem[i] = v;
  endtask
  task automatic zero_counts();
    pixcnt = 0; pixcnt4 = 0; fetchcnt = 0;
  endtask
  initial begin
    fill(16'h0);
    screen_x = 16'(-160);
    repeat (3) @(posedge clk_pix);
    #1;
    chk("reset_pix_on", pix_on1, 0);
    chk("reset_pix_de", pix_de1, 0);
    chk("reset_rom_en", rb1.rom_en, 0);
    chk("reset_rom_en4", rb4.rom_en, 0);
    rst_n = 1'b1;
    // two bits per row at the sprite edges
    fill(16'h8001); zero_counts();
    do_frame(100, 50, 1'b1);
    for (int y = 48; y < 68; y++) run_line(y);
    chk("s1_pixels", pixcnt, 32);
    chk("s1_fetches", fetchcnt, 16);
    // left clip
    fill(16'hFFFF); zero_counts();
    do_frame(-8, 50, 1'b1);
    run_line(50); run_line(51);
    chk("s2_pixels", pixcnt, 16);
    // right clip, following lines still fetch
    zero_counts();
    do_frame(632, 50, 1'b1);
    for (int y = 50; y < 53; y++) run_line(y);
    chk("s3_pixels", pixcnt, 24);
    chk("s3_fetches", fetchcnt, 3);
    // live position change mid-frame is ignored until the next frame
    for (int i = 0; i < 16; i++) mem[i] = 16'($urandom);
    zero_counts();
    do_frame(100, 50, 1'b1);
    run_line(54); run_line(55);
    spr_y = 16'sd200;
    for (int y = 56; y < 59; y++) run_line(y);
    for (int y = 64; y < 67; y++) run_line(y);
    do_frame(100, 200, 1'b1);
    run_line(199); run_line(200); run_line(215); run_line(216);
    chk("s4_fetches", fetchcnt, 9);
    // disabled sprite
    fill(16'hFFFF); zero_counts();
    do_frame(100, 50, 1'b0);
    for (int y = 50; y < 53; y++) run_line(y);
    chk("s5_fetches", fetchcnt, 0);
    chk("s5_pixels", pixcnt, 0);
    // sprite wholly in blanking, then a normal frame
    zero_counts();
    do_frame(-150, 50, 1'b1);
    run_line(50); run_line(51);
    chk("s6_pixels4", pixcnt4, 0);
    do_frame(300, 50, 1'b1);
    run_line(50);
    chk("s6_recover4", pixcnt4, 16);
    // reset in the middle of a drawn span
    zero_counts();
    do_frame(100, 50, 1'b1);
    run_line(50, 105);
    run_line(51);
    chk("s7_after_reset", pixcnt, 5);
    do_frame(100, 50, 1'b1);
    run_line(52);
    chk("s7_resumed", pixcnt, 21);
    // random placements and bitmaps
    for (int k = 0; k < 4; k++) begin
      int sx, sy;
      for (int i = 0; i < 16; i++) mem[i] = 16'($urandom);
      sx = int'($urandom_range(0, 670)) - 20;
      sy = int'($urandom_range(2, 40));
      do_frame(sx, sy, 1'b1);
      run_line(sy - 2);
      run_line(sy);
      run_line(sy + int'($urandom_range(1, 14)));
      run_line(sy + 16);
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
